// File: rtl/axibram_write_wide.sv
// AXI3 write slave that turns AW/W bursts into single-port memory writes.
// AW, W and B are decoupled by small FIFOs; one burst is in flight at a time.

module axibram_write_wide_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module axibram_write_wide #(
  parameter int ADDRESS_BITS    = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 12,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic                    wlast,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic [ADDRESS_BITS-1:0] pre_awaddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic [ADDRESS_BITS-1:0] bram_waddr,
  output logic                    bram_wen,
  output logic [DATA_WIDTH/8-1:0] bram_wstb,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  output logic [1:0]              dbg_state
);
  localparam int LSB  = $clog2(DATA_WIDTH / 8);
  localparam int STRB = DATA_WIDTH / 8;
  localparam int AW_W = ID_WIDTH + 4 + 3 + 2 + ADDRESS_BITS;
  localparam int W_W  = ID_WIDTH + 1 + STRB + DATA_WIDTH;
  localparam int B_W  = ID_WIDTH + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DROP = 2'd2} state_t;

  state_t                  state;
  logic                    ready_en;
  logic [ID_WIDTH-1:0]     cur_id;
  logic [3:0]              cur_len;
  logic [1:0]              cur_burst;
  logic [ADDRESS_BITS-1:0] cur_addr;
  logic [3:0]              beats_left;
  logic                    bad_burst;
  logic                    sticky_err;

  logic            aw_push, aw_pop, aw_empty, aw_full;
  logic [AW_W-1:0] aw_din, aw_dout;
  logic            w_push, w_pop, w_empty, w_full;
  logic [W_W-1:0]  w_din, w_dout;
  logic            b_push, b_pop, b_empty, b_full;
  logic [B_W-1:0]  b_din, b_dout;

  logic [ID_WIDTH-1:0]     h_id;
  logic [3:0]              h_len;
  logic [2:0]              h_size;
  logic [1:0]              h_burst;
  logic [ID_WIDTH-1:0]     w_id;
  logic                    w_last;
  logic                    start_ok, h_err, wrap_len_ok;
  logic                    beat, id_match, last_beat, beat_err;
  logic [ADDRESS_BITS-1:0] len_mask, addr_inc, addr_nxt;
  logic                    unused_addr_bits;

  // Low byte-lane bits and bits above the memory span alias away.
  assign unused_addr_bits = ^{awaddr[31:ADDRESS_BITS+LSB], awaddr[LSB-1:0]};

  assign awready = ready_en && !aw_full;
  assign wready  = ready_en && !w_full;
  assign aw_push = awvalid && awready;
  assign w_push  = wvalid && wready;
  assign aw_din  = {awid, awlen, awsize, awburst, awaddr[ADDRESS_BITS+LSB-1:LSB]};
  assign w_din   = {wid, wlast, wstrb, wdata};
  assign {h_id, h_len, h_size, h_burst, pre_awaddr} = aw_dout;
  assign {w_id, w_last, bram_wstb, bram_wdata}       = w_dout;

  axibram_write_wide_fifo #(.WIDTH(AW_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_aw_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(aw_push), .din(aw_din),
    .pop(aw_pop), .dout(aw_dout), .empty(aw_empty), .full(aw_full));

  axibram_write_wide_fifo #(.WIDTH(W_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_w_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(w_push), .din(w_din),
    .pop(w_pop), .dout(w_dout), .empty(w_empty), .full(w_full));

  axibram_write_wide_fifo #(.WIDTH(B_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_b_fifo (
    .aclk(aclk), .aresetn(aresetn), .push(b_push), .din(b_din),
    .pop(b_pop), .dout(b_dout), .empty(b_empty), .full(b_full));

  assign wrap_len_ok = (h_len == 4'd1) || (h_len == 4'd3) || (h_len == 4'd7) || (h_len == 4'd15);
  assign h_err = (h_size != 3'(LSB)) || (h_burst == 2'b11) ||
                 ((h_burst == 2'b10) && !wrap_len_ok);

  // Reserving a B slot before starting guarantees the final beat can always push.
  assign start_ok  = (state == IDLE) && !aw_empty && dev_ready && !b_full;
  assign aw_pop    = start_ok;
  assign beat      = (state != IDLE) && !w_empty && dev_ready;
  assign w_pop     = beat;
  assign id_match  = (w_id == cur_id);
  assign last_beat = (beats_left == 4'd0);
  assign beat_err  = !id_match || (w_last != last_beat);
  assign bram_wen  = beat && (state == WRITE) && id_match;
  assign bram_waddr = cur_addr;

  assign b_push = beat && last_beat;
  assign b_din  = {cur_id, (bad_burst || sticky_err || beat_err) ? 2'b10 : 2'b00};
  assign bvalid = !b_empty;
  assign b_pop  = bvalid && bready;
  assign {bid, bresp} = b_dout;
  assign dbg_state = state;

  assign len_mask = {{(ADDRESS_BITS-4){1'b0}}, cur_len};
  assign addr_inc = cur_addr + 1'b1;

  always_comb begin
    addr_nxt = cur_addr;
    case (cur_burst)
      2'b01:   addr_nxt = addr_inc;
      2'b10:   addr_nxt = (cur_addr & ~len_mask) | (addr_inc & len_mask);
      default: addr_nxt = cur_addr;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      ready_en    <= 1'b0;
      start_burst <= 1'b0;
      cur_id      <= '0;
      cur_len     <= '0;
      cur_burst   <= '0;
      cur_addr    <= '0;
      beats_left  <= '0;
      bad_burst   <= 1'b0;
      sticky_err  <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      start_burst <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            start_burst <= 1'b1;
            cur_id      <= h_id;
            cur_len     <= h_len;
            cur_burst   <= h_burst;
            cur_addr    <= pre_awaddr;
            beats_left  <= h_len;
            bad_burst   <= h_err;
            sticky_err  <= 1'b0;
            state       <= h_err ? DROP : WRITE;
          end
        end
        WRITE, DROP: begin
          if (beat) begin
            cur_addr   <= addr_nxt;
            beats_left <= beats_left - 1'b1;
            if (beat_err)  sticky_err <= 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
